// File: rtl/ifu_fetch_if.sv
// Fetch-side bus: instruction-memory read port, redirect input and the F/D slot handshake to decode.
interface ifu_fetch_if;
  logic [31:0] im_pc;
  logic [31:0] im_ir;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  modport master (
    output im_pc,
    input  im_ir,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc4
  );

  modport slave (
    input  im_pc,
    output im_ir,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc4
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, reads the combinational IM and fills the F/D slot.
//   state | meaning
//   IDLE  | waiting for start, PC parked at reset/redirect value
//   RUN   | fetching one word per free slot
//   FAULT | stopped on an illegal PC, sticky until reset
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  ifu_fetch_if.master bus,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  // Window end kept in 33 bits so a window touching 2^32 does not wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + ({1'b0, 32'(IM_WORDS)} << 2);

  state_t      state_q;
  logic [31:0] pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_pc4_q;
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic [31:0] fetch_count_q;

  logic        bad_pc;
  logic        slot_free;
  logic        load;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign bad_pc    = (pc_q[1:0] != 2'b00) ||
                     ({1'b0, pc_q} < {1'b0, IM_BASE}) ||
                     ({1'b0, pc_q} >= IM_END);
  assign slot_free = !out_valid_q || bus.out_ready;
  assign load      = (state_q == RUN) && slot_free && !bad_pc && !bus.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_pc4_q     <= '0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        state_q <= RUN;
      end

      if (bus.redirect_valid && state_q != FAULT) begin
        pc_q        <= bus.redirect_pc;
        out_valid_q <= 1'b0;
      end else if (state_q == RUN && slot_free && bad_pc) begin
        state_q     <= FAULT;
        fault_q     <= 1'b1;
        fault_pc_q  <= pc_q;
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_instr_q   <= bus.im_ir;
        out_pc_q      <= pc_q;
        out_pc4_q     <= pc_plus4;
        out_valid_q   <= 1'b1;
        pc_q          <= pc_plus4;
        fetch_count_q <= fetch_count_q + 32'd1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.im_pc     = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_pc4   = out_pc4_q;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: streaming, stall, redirect, fault and async reset scenarios.
module tb_ifu_fetch;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;
  logic [31:0] mem [0:1023];
  int          tests;
  int          fails;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .bus           (bus.master),
    .fault_o       (fault),
    .fault_pc_o    (fault_pc),
    .fetch_count_o (fetch_count)
  );

  assign bus.im_ir = mem[bus.im_pc[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %h want 0", bus.out_valid); end
    tests++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.out_pc4 !== 32'h0) begin fails++;
      $display("FAIL reset_slot got pc=%h instr=%h pc4=%h want 0", bus.out_pc, bus.out_instr, bus.out_pc4); end
    tests++; if (bus.im_pc !== 32'h3000) begin fails++; $display("FAIL reset_im_pc got %h want 3000", bus.im_pc); end
    tests++; if (fault !== 1'b0 || fault_pc !== 32'h0 || fetch_count !== 32'h0) begin fails++;
      $display("FAIL reset_fault got f=%h fpc=%h cnt=%h want 0", fault, fault_pc, fetch_count); end
    step();
    tests++; if (bus.out_valid !== 1'b0 || bus.im_pc !== 32'h3000) begin fails++;
      $display("FAIL idle_hold got v=%h pc=%h want 0 3000", bus.out_valid, bus.im_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    start = 1'b1;
    bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.im_pc !== 32'h3000) begin fails++;
      $display("FAIL start_latency got v=%h pc=%h want 0 3000", bus.out_valid, bus.im_pc); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'h3000 + 32'(4 * i);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (32'hA000_0000 | 32'(i)) ||
          bus.out_pc4 !== exp_pc + 32'd4) begin
        fails++;
        $display("FAIL stream_%0d got v=%h pc=%h instr=%h pc4=%h want pc=%h", i, bus.out_valid, bus.out_pc,
                 bus.out_instr, bus.out_pc4, exp_pc);
      end
    end
    tests++; if (fetch_count !== 32'd4) begin fails++; $display("FAIL stream_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    start = 1'b1;
    bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3004 || bus.out_instr !== 32'hA000_0001 ||
          bus.im_pc !== 32'h3008 || fetch_count !== 32'd2) begin
        fails++;
        $display("FAIL stall_%0d got v=%h pc=%h instr=%h im_pc=%h cnt=%0d want 1 3004 A0000001 3008 2", i,
                 bus.out_valid, bus.out_pc, bus.out_instr, bus.im_pc, fetch_count);
      end
    end
    bus.out_ready = 1'b1;
    step();
    tests++; if (bus.out_pc !== 32'h3008 || bus.out_instr !== 32'hA000_0002 || fetch_count !== 32'd3) begin fails++;
      $display("FAIL stall_release got pc=%h instr=%h cnt=%0d want 3008 A0000002 3", bus.out_pc, bus.out_instr, fetch_count); end
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3100;
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests++; if (bus.out_valid !== 1'b0 || bus.im_pc !== 32'h3100 || fetch_count !== 32'd3) begin fails++;
      $display("FAIL redirect_flush got v=%h im_pc=%h cnt=%0d want 0 3100 3", bus.out_valid, bus.im_pc, fetch_count); end
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3100 || bus.out_instr !== 32'hA000_0040) begin fails++;
      $display("FAIL redirect_target got v=%h pc=%h instr=%h want 1 3100 A0000040", bus.out_valid, bus.out_pc, bus.out_instr); end
    // Misaligned redirect target faults only when it is next presented for load.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3102;
    step();
    bus.redirect_valid = 1'b0;
    tests++; if (fault !== 1'b0 || bus.out_valid !== 1'b0 || bus.im_pc !== 32'h3102) begin fails++;
      $display("FAIL misalign_pre got f=%h v=%h im_pc=%h want 0 0 3102", fault, bus.out_valid, bus.im_pc); end
    step();
    tests++; if (fault !== 1'b1 || fault_pc !== 32'h3102 || bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL misalign_fault got f=%h fpc=%h v=%h want 1 3102 0", fault, fault_pc, bus.out_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3000;
    start = 1'b1;
    step();
    step();
    bus.redirect_valid = 1'b0;
    start = 1'b0;
    tests++; if (fault !== 1'b1 || bus.im_pc !== 32'h3102 || bus.out_valid !== 1'b0 || fetch_count !== 32'd4) begin fails++;
      $display("FAIL fault_sticky got f=%h im_pc=%h v=%h cnt=%0d want 1 3102 0 4", fault, bus.im_pc, bus.out_valid, fetch_count); end
  endtask

  task automatic test_upper_bound();
    do_reset();
    start = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3FFC;
    step();
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3FFC || bus.out_instr !== 32'hA000_03FF ||
                 bus.out_pc4 !== 32'h4000) begin fails++;
      $display("FAIL last_word got v=%h pc=%h instr=%h pc4=%h want 1 3FFC A00003FF 4000", bus.out_valid, bus.out_pc,
               bus.out_instr, bus.out_pc4); end
    step();
    tests++; if (fault !== 1'b1 || fault_pc !== 32'h4000 || bus.out_valid !== 1'b0 || fetch_count !== 32'd1) begin fails++;
      $display("FAIL upper_fault got f=%h fpc=%h v=%h cnt=%0d want 1 4000 0 1", fault, fault_pc, bus.out_valid, fetch_count); end
  endtask

  task automatic test_lower_bound();
    do_reset();
    start = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h2FFC;
    step();
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    tests++; if (fault !== 1'b1 || fault_pc !== 32'h2FFC || bus.out_valid !== 1'b0 || fetch_count !== 32'd0) begin fails++;
      $display("FAIL lower_fault got f=%h fpc=%h v=%h cnt=%0d want 1 2FFC 0 0", fault, fault_pc, bus.out_valid, fetch_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1;
    bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || fetch_count !== 32'h0 ||
                 bus.im_pc !== 32'h3000) begin fails++;
      $display("FAIL async_reset got v=%h pc=%h instr=%h cnt=%0d im_pc=%h want 0 0 0 0 3000", bus.out_valid, bus.out_pc,
               bus.out_instr, fetch_count, bus.im_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    tests++; if (bus.out_valid !== 1'b0 || bus.im_pc !== 32'h3000 || fetch_count !== 32'h0) begin fails++;
      $display("FAIL post_reset_idle got v=%h im_pc=%h cnt=%0d want 0 3000 0", bus.out_valid, bus.im_pc, fetch_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    rst_n = 1'b0;
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall_redirect();
    test_upper_bound();
    test_lower_bound();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
